csr_mmode_unit: RTL and testbench
=================================

Name: csr_mmode_unit

Overview:
- Parametrised machine-mode CSR file and trap controller for the single-issue core. It sits beside the execute stage.
- Generalises the existing CSR block with:
  - configurable XLEN and hart ID;
  - three interrupt sources (software, timer, external) with fixed priority;
  - synchronous exceptions with mtval;
  - vectored mtvec;
  - mcountinhibit;
  - illegal-CSR detection.
- Produces the redirect PC for trap entry and mret.

Parameters:
- XLEN, 64, data/address width (32 or 64).
- HART_ID, 0, value returned by mhartid.
- VECTORED_EN, 1, 1 allows mtvec.MODE=1 (vectored); 0 forces MODE=0.
- CNT_W, 64, width of mcycle/minstret (≤64); zero-extended to XLEN on read.

Ports:
- clk in 1 core clock.
- rst in 1 asynchronous active-high reset.
- inst_valid in 1 instruction in execute is valid this cycle.
- csr_index in 12 CSR address.
- csr_ctrl in 2: 00 none, 01 rw, 10 rs, 11 rc.
- csr_src in 1: 1 selects imm_csr, 0 selects rs1_data.
- rs1_data in XLEN register operand.
- imm_csr in XLEN zero-extended uimm.
- inst_addr in XLEN PC of the instruction.
- inst_ecall in 1 ecall.
- inst_ebreak in 1 ebreak.
- inst_mret in 1 mret.
- exc_valid in 1 other synchronous exception from upstream.
- exc_code in 4 cause for exc_valid.
- exc_tval in XLEN mtval for exc_valid.
- irq_msip in 1 async software interrupt.
- irq_mtip in 1 async timer interrupt.
- irq_meip in 1 async external interrupt.
- csr_read out XLEN old CSR value (combinational).
- redirect out 1 trap entry or mret this cycle.
- redirect_pc out XLEN target PC.
- inst_kill out 1 instruction must not commit (trap taken).

Behaviour:
- **Reset:**
  - All CSRs are 0, except mcountinhibit=0 and misa per XLEN (MXL=1 or 2, bit I set).
  - irq sync flops are 0.
  - Outputs 0.
- **irq synchronisation:** each irq_* passes a 2-flop synchroniser. mip.MSIP/MTIP/MEIP (bits 3/7/11) mirror the synchronised values and are read-only; writes to mip are ignored.
- **Write intent:**
  - rw: always writes.
  - rs/rc: writes only if the source operand != 0.
  - New value: rw=src, rs=old|src, rc=old&~src.
- **Illegal access:** treated as exception cause 2, mtval=0. Triggered by:
  - an unimplemented csr_index with csr_ctrl!=00;
  - write intent to a read-only CSR (index[11:10]==11).
- **Priority per valid instruction, highest first:**
  - interrupt (mstatus.MIE & |(mip&mie)), order MEI(11) > MSI(3) > MTI(7);
  - illegal CSR (2);
  - exc_valid (exc_code);
  - ebreak (3), mtval=inst_addr;
  - ecall (11).
- **Trap entry** (same cycle: redirect=1, inst_kill=1):
  - mepc=inst_addr[XLEN-1:2]<<2;
  - mcause={irq,cause};
  - mtval as above (0 for interrupts and ecall);
  - MPIE=MIE, MIE=0, MPP=11.
  - No CSR write occurs and minstret does not increment.
- **redirect_pc:**
  - Direct mode: mtvec.BASE<<2.
  - Vectored and interrupt: (BASE<<2)+4*cause.
- **mret** (no trap pending): redirect=1, redirect_pc=mepc, MIE=MPIE, MPIE=1, MPP=11 (M-only). The instruction retires.
- **Masked fields:**
  - mstatus writable bits are MIE(3), MPIE(7); MPP reads 11.
  - mie writable bits are 3, 7, 11.
  - mtvec.MODE bit1 reads 0; bit0 is writable only if VECTORED_EN.
  - mepc[1:0] reads 0.
- **mcycle:** increments each cycle unless mcountinhibit.CY. A CSR write has precedence, and no increment occurs that cycle.
- **minstret:** increments on each valid, non-killed instruction unless mcountinhibit.IR. A write has precedence.
- **Counter width:** counters wrap at 2^CNT_W. On XLEN=32, mcycleh/minstreth (0xB80/0xB82) access bits [63:32].
- **Simultaneous events:** an interrupt arriving on the same cycle as an mret is taken first, and mepc gets the mret address.
- **Reset mid-operation:** reset clears all state asynchronously. The first instruction after release is not killed unless an enabled interrupt is pending, which is impossible because MIE=0.

Decomposition:
- **csr_pkg:**
  - CSR address constants (mstatus 0x300, misa 0x301, mie 0x304, mtvec 0x305, mcountinhibit 0x320, mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343, mip 0x344, mcycle 0xB00, minstret 0xB02, mvendorid 0xF11, marchid 0xF12, mimpid 0xF13, mhartid 0xF14);
  - cause codes;
  - mstatus/mip bit positions;
  - csr_ctrl encodings.
- **Sub-module csr_counter:** parametrised CNT_W. Inputs: inc, inhibit, wr_en, wr_lo, wr_hi, wdata. Instanced for mcycle and minstret.

Test Plan:
- Write mtvec=0x8000_0001 (VECTORED_EN=1), mie=0x80, mstatus=0x8, then pulse irq_mtip → 2 cycles later mip=0x80. The next valid instruction at 0x8000_0100 gives redirect_pc=0x8000_001C, mcause=0x8000_0000_0000_0007, mepc=0x8000_0100, mstatus=0x1880, inst_kill=1.
- ecall at PC 0x1000 with mtvec=0x2000 → redirect_pc=0x2000, mcause=11. A following mret gives redirect_pc=0x1000, mstatus.MIE restored to MPIE and MPIE=1.
- Same instruction with irq_meip and irq_mtip both pending and enabled → mcause=0x8…0B.
- csrrw to 0xF11 → cause 2, no write. csrrs 0xF14 with rs1=0 → csr_read=HART_ID, no trap.
- mcountinhibit=0x5 → mcycle and minstret hold over 10 cycles. Writing mcycle=0xFFFF_FFFF_FFFF_FFFF then clearing inhibit → the counter wraps to 0 on the next cycle.
- Assert rst mid-trap cycle → all CSRs, redirect and inst_kill read 0 immediately (asynchronous).

Source files
------------

// File: rtl/csr_mmode_unit_pkg.sv
// Shared constants and types for the machine-mode CSR file and trap controller.
package csr_mmode_unit_pkg;

    localparam logic [11:0] CSR_MSTATUS       = 12'h300;
    localparam logic [11:0] CSR_MISA          = 12'h301;
    localparam logic [11:0] CSR_MIE           = 12'h304;
    localparam logic [11:0] CSR_MTVEC         = 12'h305;
    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
    localparam logic [11:0] CSR_MEPC          = 12'h341;
    localparam logic [11:0] CSR_MCAUSE        = 12'h342;
    localparam logic [11:0] CSR_MTVAL         = 12'h343;
    localparam logic [11:0] CSR_MIP           = 12'h344;
    localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
    localparam logic [11:0] CSR_MVENDORID     = 12'hF11;
    localparam logic [11:0] CSR_MARCHID       = 12'hF12;
    localparam logic [11:0] CSR_MIMPID        = 12'hF13;
    localparam logic [11:0] CSR_MHARTID       = 12'hF14;

    localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;
    localparam logic [3:0] CAUSE_BREAK   = 4'd3;
    localparam logic [3:0] CAUSE_ECALL_M = 4'd11;
    localparam logic [3:0] CAUSE_MSI     = 4'd3;
    localparam logic [3:0] CAUSE_MTI     = 4'd7;
    localparam logic [3:0] CAUSE_MEI     = 4'd11;

    localparam int unsigned MSTATUS_MIE  = 3;
    localparam int unsigned MSTATUS_MPIE = 7;
    localparam int unsigned MIP_MSI      = 3;
    localparam int unsigned MIP_MTI      = 7;
    localparam int unsigned MIP_MEI      = 11;

    typedef enum logic [1:0] {
        CTRL_NONE = 2'b00,
        CTRL_RW   = 2'b01,
        CTRL_RS   = 2'b10,
        CTRL_RC   = 2'b11
    } csr_ctrl_e;

    typedef struct packed {
        logic       take;
        logic       irq;
        logic [3:0] cause;
    } trap_t;

endpackage

// File: rtl/csr_mmode_unit_if.sv
// Execute-stage bundle between the pipeline and the CSR/trap unit.
interface csr_mmode_unit_if #(
    parameter int unsigned XLEN = 64
);
    logic            inst_valid;
    logic [11:0]     csr_index;
    logic [1:0]      csr_ctrl;
    logic            csr_src;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] imm_csr;
    logic [XLEN-1:0] inst_addr;
    logic            inst_ecall;
    logic            inst_ebreak;
    logic            inst_mret;
    logic            exc_valid;
    logic [3:0]      exc_code;
    logic [XLEN-1:0] exc_tval;
    logic            irq_msip;
    logic            irq_mtip;
    logic            irq_meip;
    logic [XLEN-1:0] csr_read;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            inst_kill;

    modport master (
        output inst_valid, csr_index, csr_ctrl, csr_src, rs1_data, imm_csr, inst_addr,
               inst_ecall, inst_ebreak, inst_mret, exc_valid, exc_code, exc_tval,
               irq_msip, irq_mtip, irq_meip,
        input  csr_read, redirect, redirect_pc, inst_kill
    );

    modport slave (
        input  inst_valid, csr_index, csr_ctrl, csr_src, rs1_data, imm_csr, inst_addr,
               inst_ecall, inst_ebreak, inst_mret, exc_valid, exc_code, exc_tval,
               irq_msip, irq_mtip, irq_meip,
        output csr_read, redirect, redirect_pc, inst_kill
    );
endinterface

// File: rtl/csr_mmode_unit_counter.sv
// Free-running event counter with inhibit and half-word write ports (mcycle/minstret).
module csr_counter #(
    parameter int unsigned CNT_W = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    input  logic        inhibit,
    input  logic        wr_en,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [63:0] wdata,
    output logic [63:0] cnt
);
    logic [CNT_W-1:0] cnt_q;
    logic [63:0]      merged;

    assign cnt    = 64'(cnt_q);
    assign merged = {wr_hi ? wdata[63:32] : cnt[63:32], wr_lo ? wdata[31:0] : cnt[31:0]};

    // A write wins over the increment in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (wr_en) begin
            cnt_q <= CNT_W'(merged);
        end else if (inc && !inhibit) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end
endmodule

// File: rtl/csr_mmode_unit.sv
// Machine-mode CSR file and trap controller; resolves traps/mret and the redirect PC
// in the same cycle as the instruction in execute.
module csr_mmode_unit
    import csr_mmode_unit_pkg::*;
#(
    parameter int unsigned XLEN        = 64,
    parameter int unsigned HART_ID     = 0,
    parameter bit          VECTORED_EN = 1'b1,
    parameter int unsigned CNT_W       = 64
) (
    input logic             clk,
    input logic             rst,
    csr_mmode_unit_if.slave bus
);
    localparam logic [XLEN-1:0] MISA_VAL =
        (XLEN'(XLEN == 64 ? 2 : 1) << (XLEN - 2)) | (XLEN'(1) << 8);

    logic [2:0]      irq_s1, irq_s2;   // {mei, mti, msi}
    logic            st_mie, st_mpie, cy_inh, ir_inh, mtvec_mode;
    logic [2:0]      mie_q;            // {mei, mti, msi}
    logic [XLEN-3:0] mtvec_base, mepc_q;
    logic [XLEN-1:0] mscratch_q, mcause_q, mtval_q;
    logic [63:0]     mcycle, minstret;

    logic [XLEN-1:0] rdata, src, wdata, tval, tvec_base, trap_pc, mip_val, mie_val;
    logic            hit, wr_intent, illegal, csr_we, hi_sel, mret_go;
    logic [2:0]      irq_en;
    trap_t           trap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_s1 <= '0;
            irq_s2 <= '0;
        end else begin
            irq_s1 <= {bus.irq_meip, bus.irq_mtip, bus.irq_msip};
            irq_s2 <= irq_s1;
        end
    end

    assign mip_val = XLEN'({irq_s2[2], 3'b0, irq_s2[1], 3'b0, irq_s2[0], 3'b0});
    assign mie_val = XLEN'({mie_q[2], 3'b0, mie_q[1], 3'b0, mie_q[0], 3'b0});

    // Read mux; hit flags an implemented address.
    always_comb begin
        rdata = '0;
        hit   = 1'b1;
        case (bus.csr_index)
            CSR_MSTATUS:       rdata = XLEN'({2'b11, 3'b0, st_mpie, 3'b0, st_mie, 3'b0});
            CSR_MISA:          rdata = MISA_VAL;
            CSR_MIE:           rdata = mie_val;
            CSR_MTVEC:         rdata = {mtvec_base, 1'b0, mtvec_mode};
            CSR_MCOUNTINHIBIT: rdata = XLEN'({ir_inh, 1'b0, cy_inh});
            CSR_MSCRATCH:      rdata = mscratch_q;
            CSR_MEPC:          rdata = {mepc_q, 2'b00};
            CSR_MCAUSE:        rdata = mcause_q;
            CSR_MTVAL:         rdata = mtval_q;
            CSR_MIP:           rdata = mip_val;
            CSR_MCYCLE:        rdata = XLEN'(mcycle);
            CSR_MINSTRET:      rdata = XLEN'(minstret);
            CSR_MCYCLEH:       if (XLEN == 32) rdata = XLEN'(mcycle >> 32); else hit = 1'b0;
            CSR_MINSTRETH:     if (XLEN == 32) rdata = XLEN'(minstret >> 32); else hit = 1'b0;
            CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID: rdata = '0;
            CSR_MHARTID:       rdata = XLEN'(HART_ID);
            default:           hit = 1'b0;
        endcase
    end

    assign src = bus.csr_src ? bus.imm_csr : bus.rs1_data;

    always_comb begin
        wr_intent = 1'b0;
        wdata     = src;
        case (bus.csr_ctrl)
            CTRL_RW: wr_intent = 1'b1;
            CTRL_RS: begin wr_intent = |src; wdata = rdata | src;  end
            CTRL_RC: begin wr_intent = |src; wdata = rdata & ~src; end
            default: ;
        endcase
    end

    assign illegal = (bus.csr_ctrl != CTRL_NONE) &&
                     (!hit || (wr_intent && bus.csr_index[11:10] == 2'b11));
    assign irq_en  = irq_s2 & mie_q & {3{st_mie}};

    // Trap arbitration, highest priority first.
    always_comb begin
        trap = '0;
        tval = '0;
        if (bus.inst_valid) begin
            if (|irq_en) begin
                trap = '{take: 1'b1, irq: 1'b1,
                         cause: irq_en[2] ? CAUSE_MEI : (irq_en[0] ? CAUSE_MSI : CAUSE_MTI)};
            end else if (illegal) begin
                trap = '{take: 1'b1, irq: 1'b0, cause: CAUSE_ILLEGAL};
            end else if (bus.exc_valid) begin
                trap = '{take: 1'b1, irq: 1'b0, cause: bus.exc_code};
                tval = bus.exc_tval;
            end else if (bus.inst_ebreak) begin
                trap = '{take: 1'b1, irq: 1'b0, cause: CAUSE_BREAK};
                tval = bus.inst_addr;
            end else if (bus.inst_ecall) begin
                trap = '{take: 1'b1, irq: 1'b0, cause: CAUSE_ECALL_M};
            end
        end
    end

    assign csr_we    = bus.inst_valid && !trap.take && wr_intent;
    assign mret_go   = bus.inst_valid && !trap.take && bus.inst_mret;
    assign tvec_base = {mtvec_base, 2'b00};
    assign trap_pc   = (mtvec_mode && trap.irq) ? tvec_base + XLEN'({trap.cause, 2'b00}) : tvec_base;

    // Outputs forced low while reset is asserted.
    assign bus.csr_read    = rst ? '0 : rdata;
    assign bus.redirect    = !rst && (trap.take || mret_go);
    assign bus.inst_kill   = !rst && trap.take;
    assign bus.redirect_pc = rst ? '0 : (trap.take ? trap_pc : (mret_go ? {mepc_q, 2'b00} : '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_mie     <= 1'b0;
            st_mpie    <= 1'b0;
            mie_q      <= '0;
            mtvec_base <= '0;
            mtvec_mode <= 1'b0;
            cy_inh     <= 1'b0;
            ir_inh     <= 1'b0;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
        end else if (trap.take) begin
            mepc_q   <= bus.inst_addr[XLEN-1:2];
            mcause_q <= trap.irq ? {1'b1, (XLEN-1)'(trap.cause)} : XLEN'(trap.cause);
            mtval_q  <= tval;
            st_mpie  <= st_mie;
            st_mie   <= 1'b0;
        end else begin
            if (csr_we) begin
                case (bus.csr_index)
                    CSR_MSTATUS: begin
                        st_mie  <= wdata[MSTATUS_MIE];
                        st_mpie <= wdata[MSTATUS_MPIE];
                    end
                    CSR_MIE:     mie_q <= {wdata[MIP_MEI], wdata[MIP_MTI], wdata[MIP_MSI]};
                    CSR_MTVEC: begin
                        mtvec_base <= wdata[XLEN-1:2];
                        mtvec_mode <= VECTORED_EN & wdata[0];
                    end
                    CSR_MCOUNTINHIBIT: begin
                        cy_inh <= wdata[0];
                        ir_inh <= wdata[2];
                    end
                    CSR_MSCRATCH: mscratch_q <= wdata;
                    CSR_MEPC:     mepc_q     <= wdata[XLEN-1:2];
                    CSR_MCAUSE:   mcause_q   <= wdata;
                    CSR_MTVAL:    mtval_q    <= wdata;
                    default: ;
                endcase
            end
            if (mret_go) begin
                st_mie  <= st_mpie;
                st_mpie <= 1'b1;
            end
        end
    end

    // On RV32 the high-half aliases land in bits [63:32]; RV64 writes both halves at once.
    assign hi_sel = (bus.csr_index == CSR_MCYCLEH) || (bus.csr_index == CSR_MINSTRETH);

    csr_counter #(.CNT_W(CNT_W)) u_mcycle (
        .clk     (clk),
        .rst     (rst),
        .inc     (1'b1),
        .inhibit (cy_inh),
        .wr_en   (csr_we && (bus.csr_index == CSR_MCYCLE || (XLEN == 32 && bus.csr_index == CSR_MCYCLEH))),
        .wr_lo   ((XLEN == 64) || !hi_sel),
        .wr_hi   ((XLEN == 64) || hi_sel),
        .wdata   (hi_sel ? (64'(wdata) << 32) : 64'(wdata)),
        .cnt     (mcycle)
    );

    csr_counter #(.CNT_W(CNT_W)) u_minstret (
        .clk     (clk),
        .rst     (rst),
        .inc     (bus.inst_valid && !trap.take),
        .inhibit (ir_inh),
        .wr_en   (csr_we && (bus.csr_index == CSR_MINSTRET || (XLEN == 32 && bus.csr_index == CSR_MINSTRETH))),
        .wr_lo   ((XLEN == 64) || !hi_sel),
        .wr_hi   ((XLEN == 64) || hi_sel),
        .wdata   (hi_sel ? (64'(wdata) << 32) : 64'(wdata)),
        .cnt     (minstret)
    );

endmodule

// File: tb/tb_csr_mmode_unit.sv
// Directed bench for csr_mmode_unit: reset, CSR access, traps, interrupts, counters.
module tb_csr_mmode_unit;
    import csr_mmode_unit_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    logic [63:0] v;

    always #5 clk = ~clk;

    csr_mmode_unit_if #(.XLEN(64)) bus ();

    csr_mmode_unit #(.XLEN(64), .HART_ID(5), .VECTORED_EN(1'b1), .CNT_W(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic clear_inst();
        bus.inst_valid = 1'b0; bus.csr_index = '0; bus.csr_ctrl = CTRL_NONE; bus.csr_src = 1'b0;
        bus.rs1_data = '0; bus.imm_csr = '0; bus.inst_addr = '0; bus.inst_ecall = 1'b0;
        bus.inst_ebreak = 1'b0; bus.inst_mret = 1'b0; bus.exc_valid = 1'b0; bus.exc_code = '0;
        bus.exc_tval = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(negedge clk); clear_inst(); end
    endtask

    task automatic issue(input logic [1:0] ctrl, input logic [11:0] idx, input logic [63:0] data,
                         input logic [63:0] pc);
        @(negedge clk); clear_inst();
        bus.inst_valid = 1'b1; bus.csr_ctrl = ctrl; bus.csr_index = idx;
        bus.rs1_data = data; bus.inst_addr = pc;
        #1;
    endtask

    task automatic issue_sys(input logic ecall, input logic ebreak, input logic mret, input logic exc,
                             input logic [3:0] code, input logic [63:0] etval, input logic [63:0] pc);
        @(negedge clk); clear_inst();
        bus.inst_valid = 1'b1; bus.inst_ecall = ecall; bus.inst_ebreak = ebreak; bus.inst_mret = mret;
        bus.exc_valid = exc; bus.exc_code = code; bus.exc_tval = etval; bus.inst_addr = pc;
        #1;
    endtask

    task automatic rd(input logic [11:0] idx, output logic [63:0] val);
        issue(CTRL_RS, idx, 64'h0, 64'h0);
        val = bus.csr_read;
    endtask

    task automatic test_reset();
        rst = 1'b1; clear_inst();
        bus.irq_msip = 1'b0; bus.irq_mtip = 1'b0; bus.irq_meip = 1'b0;
        repeat (3) @(negedge clk);
        bus.inst_valid = 1'b1; bus.inst_ecall = 1'b1; bus.csr_index = CSR_MISA; #1;
        n_chk++; if (bus.redirect !== 1'b0) begin n_fail++; $display("FAIL rst_redirect: got %0h want 0", bus.redirect); end
        n_chk++; if (bus.inst_kill !== 1'b0) begin n_fail++; $display("FAIL rst_kill: got %0h want 0", bus.inst_kill); end
        n_chk++; if (bus.csr_read !== 64'h0) begin n_fail++; $display("FAIL rst_csr_read: got %h want 0", bus.csr_read); end
        @(negedge clk); clear_inst(); rst = 1'b0;
        rd(CSR_MSTATUS, v);
        n_chk++; if (v !== 64'h1800) begin n_fail++; $display("FAIL rst_mstatus: got %h want 1800", v); end
        rd(CSR_MISA, v);
        n_chk++; if (v !== 64'h8000_0000_0000_0100) begin n_fail++; $display("FAIL misa: got %h want 8000000000000100", v); end
        rd(CSR_MHARTID, v);
        n_chk++; if (v !== 64'h5) begin n_fail++; $display("FAIL mhartid: got %h want 5", v); end
        rd(CSR_MTVEC, v);
        n_chk++; if (v !== 64'h0) begin n_fail++; $display("FAIL rst_mtvec: got %h want 0", v); end
    endtask

    task automatic test_csr_rw();
        issue(CTRL_RW, CSR_MSCRATCH, 64'hA5A5, 64'h0);
        issue(CTRL_RS, CSR_MSCRATCH, 64'h0F00, 64'h0);
        n_chk++; if (bus.csr_read !== 64'hA5A5) begin n_fail++; $display("FAIL rw_old: got %h want a5a5", bus.csr_read); end
        issue(CTRL_RC, CSR_MSCRATCH, 64'h00A0, 64'h0);
        n_chk++; if (bus.csr_read !== 64'hAFA5) begin n_fail++; $display("FAIL rs_value: got %h want afa5", bus.csr_read); end
        rd(CSR_MSCRATCH, v);
        n_chk++; if (v !== 64'hAF05) begin n_fail++; $display("FAIL rc_value: got %h want af05", v); end
        issue(CTRL_RW, CSR_MSTATUS, '1, 64'h0);
        rd(CSR_MSTATUS, v);
        n_chk++; if (v !== 64'h1888) begin n_fail++; $display("FAIL mstatus_mask: got %h want 1888", v); end
        issue(CTRL_RW, CSR_MSTATUS, 64'h0, 64'h0);
        issue(CTRL_RW, CSR_MIE, '1, 64'h0);
        rd(CSR_MIE, v);
        n_chk++; if (v !== 64'h888) begin n_fail++; $display("FAIL mie_mask: got %h want 888", v); end
        issue(CTRL_RW, CSR_MIE, 64'h0, 64'h0);
        issue(CTRL_RW, CSR_MTVEC, '1, 64'h0);
        rd(CSR_MTVEC, v);
        n_chk++; if (v !== 64'hFFFF_FFFF_FFFF_FFFD) begin n_fail++; $display("FAIL mtvec_mask: got %h want fffffffffffffffd", v); end
        issue(CTRL_RW, CSR_MEPC, '1, 64'h0);
        rd(CSR_MEPC, v);
        n_chk++; if (v !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_fail++; $display("FAIL mepc_mask: got %h want fffffffffffffffc", v); end
        issue(CTRL_RW, CSR_MIP, 64'hFFF, 64'h0);
        rd(CSR_MIP, v);
        n_chk++; if (v !== 64'h0) begin n_fail++; $display("FAIL mip_ro: got %h want 0", v); end
        issue(CTRL_RW, CSR_MTVEC, 64'h0, 64'h0);
    endtask

    task automatic test_illegal();
        issue(CTRL_RW, CSR_MVENDORID, 64'h55, 64'h400);
        n_chk++; if (bus.inst_kill !== 1'b1) begin n_fail++; $display("FAIL ro_write_kill: got %0h want 1", bus.inst_kill); end
        n_chk++; if (bus.redirect_pc !== 64'h0) begin n_fail++; $display("FAIL ro_write_pc: got %h want 0", bus.redirect_pc); end
        rd(CSR_MCAUSE, v);
        n_chk++; if (v !== 64'h2) begin n_fail++; $display("FAIL illegal_cause: got %h want 2", v); end
        rd(CSR_MEPC, v);
        n_chk++; if (v !== 64'h400) begin n_fail++; $display("FAIL illegal_mepc: got %h want 400", v); end
        rd(CSR_MVENDORID, v);
        n_chk++; if (v !== 64'h0) begin n_fail++; $display("FAIL ro_nowrite: got %h want 0", v); end
        n_chk++; if (bus.redirect !== 1'b0) begin n_fail++; $display("FAIL ro_read_redirect: got %0h want 0", bus.redirect); end
        issue(CTRL_RS, 12'h7C0, 64'h0, 64'h404);
        n_chk++; if (bus.inst_kill !== 1'b1) begin n_fail++; $display("FAIL unimpl_kill: got %0h want 1", bus.inst_kill); end
        issue(CTRL_RS, CSR_MHARTID, 64'h0, 64'h408);
        n_chk++; if (bus.csr_read !== 64'h5 || bus.inst_kill !== 1'b0) begin
            n_fail++; $display("FAIL hartid_rs0: got read=%h kill=%0h want 5/0", bus.csr_read, bus.inst_kill); end
    endtask

    task automatic test_ecall_mret();
        issue(CTRL_RW, CSR_MTVEC, 64'h2000, 64'h0);
        issue(CTRL_RW, CSR_MSTATUS, 64'h8, 64'h0);
        issue_sys(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 64'h0, 64'h1000);
        n_chk++; if (bus.redirect !== 1'b1 || bus.inst_kill !== 1'b1) begin
            n_fail++; $display("FAIL ecall_flags: got redirect=%0h kill=%0h want 1/1", bus.redirect, bus.inst_kill); end
        n_chk++; if (bus.redirect_pc !== 64'h2000) begin n_fail++; $display("FAIL ecall_pc: got %h want 2000", bus.redirect_pc); end
        rd(CSR_MCAUSE, v);
        n_chk++; if (v !== 64'hB) begin n_fail++; $display("FAIL ecall_cause: got %h want b", v); end
        rd(CSR_MSTATUS, v);
        n_chk++; if (v !== 64'h1880) begin n_fail++; $display("FAIL ecall_mstatus: got %h want 1880", v); end
        issue_sys(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 64'h0, 64'h1004);
        n_chk++; if (bus.redirect !== 1'b1 || bus.inst_kill !== 1'b0) begin
            n_fail++; $display("FAIL mret_flags: got redirect=%0h kill=%0h want 1/0", bus.redirect, bus.inst_kill); end
        n_chk++; if (bus.redirect_pc !== 64'h1000) begin n_fail++; $display("FAIL mret_pc: got %h want 1000", bus.redirect_pc); end
        rd(CSR_MSTATUS, v);
        n_chk++; if (v !== 64'h1888) begin n_fail++; $display("FAIL mret_mstatus: got %h want 1888", v); end
    endtask

    task automatic test_exceptions();
        issue_sys(1'b1, 1'b0, 1'b0, 1'b1, 4'd5, 64'hDEAD, 64'h1100);
        n_chk++; if (bus.redirect_pc !== 64'h2000) begin n_fail++; $display("FAIL exc_pc: got %h want 2000", bus.redirect_pc); end
        rd(CSR_MCAUSE, v);
        n_chk++; if (v !== 64'h5) begin n_fail++; $display("FAIL exc_over_ecall: got %h want 5", v); end
        rd(CSR_MTVAL, v);
        n_chk++; if (v !== 64'hDEAD) begin n_fail++; $display("FAIL exc_tval: got %h want dead", v); end
        issue_sys(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 64'h0, 64'h1236);
        rd(CSR_MCAUSE, v);
        n_chk++; if (v !== 64'h3) begin n_fail++; $display("FAIL ebreak_cause: got %h want 3", v); end
        rd(CSR_MTVAL, v);
        n_chk++; if (v !== 64'h1236) begin n_fail++; $display("FAIL ebreak_tval: got %h want 1236", v); end
        rd(CSR_MEPC, v);
        n_chk++; if (v !== 64'h1234) begin n_fail++; $display("FAIL ebreak_mepc: got %h want 1234", v); end
    endtask

    task automatic test_irq_timer();
        issue(CTRL_RW, CSR_MTVEC, 64'h8000_0001, 64'h0);
        issue(CTRL_RW, CSR_MIE, 64'h80, 64'h0);
        issue(CTRL_RW, CSR_MSTATUS, 64'h8, 64'h0);
        @(negedge clk); clear_inst(); bus.irq_mtip = 1'b1;
        @(negedge clk); bus.csr_index = CSR_MIP; #1;
        n_chk++; if (bus.csr_read !== 64'h0) begin n_fail++; $display("FAIL mip_sync1: got %h want 0", bus.csr_read); end
        @(negedge clk); bus.csr_index = CSR_MIP; #1;
        n_chk++; if (bus.csr_read !== 64'h80) begin n_fail++; $display("FAIL mip_sync2: got %h want 80", bus.csr_read); end
        issue(CTRL_NONE, 12'h0, 64'h0, 64'h8000_0100);
        n_chk++; if (bus.inst_kill !== 1'b1 || bus.redirect !== 1'b1) begin
            n_fail++; $display("FAIL mti_flags: got kill=%0h redirect=%0h want 1/1", bus.inst_kill, bus.redirect); end
        n_chk++; if (bus.redirect_pc !== 64'h8000_001C) begin n_fail++; $display("FAIL mti_vector: got %h want 8000001c", bus.redirect_pc); end
        bus.irq_mtip = 1'b0;
        rd(CSR_MCAUSE, v);
        n_chk++; if (v !== 64'h8000_0000_0000_0007) begin n_fail++; $display("FAIL mti_cause: got %h want 8000000000000007", v); end
        rd(CSR_MEPC, v);
        n_chk++; if (v !== 64'h8000_0100) begin n_fail++; $display("FAIL mti_mepc: got %h want 80000100", v); end
        rd(CSR_MSTATUS, v);
        n_chk++; if (v !== 64'h1880) begin n_fail++; $display("FAIL mti_mstatus: got %h want 1880", v); end
    endtask

    task automatic test_irq_priority();
        issue(CTRL_RW, CSR_MIE, 64'h880, 64'h0);
        issue(CTRL_RW, CSR_MSTATUS, 64'h8, 64'h0);
        @(negedge clk); clear_inst(); bus.irq_meip = 1'b1; bus.irq_mtip = 1'b1;
        idle(2);
        issue_sys(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 64'h0, 64'h3000);
        n_chk++; if (bus.inst_kill !== 1'b1) begin n_fail++; $display("FAIL irq_vs_mret_kill: got %0h want 1", bus.inst_kill); end
        n_chk++; if (bus.redirect_pc !== 64'h8000_002C) begin n_fail++; $display("FAIL mei_vector: got %h want 8000002c", bus.redirect_pc); end
        bus.irq_meip = 1'b0; bus.irq_mtip = 1'b0;
        rd(CSR_MCAUSE, v);
        n_chk++; if (v !== 64'h8000_0000_0000_000B) begin n_fail++; $display("FAIL mei_cause: got %h want 800000000000000b", v); end
        rd(CSR_MEPC, v);
        n_chk++; if (v !== 64'h3000) begin n_fail++; $display("FAIL mei_mepc: got %h want 3000", v); end
        issue(CTRL_RW, CSR_MIE, 64'h0, 64'h0);
    endtask

    task automatic test_counters();
        issue(CTRL_RW, CSR_MCOUNTINHIBIT, 64'h5, 64'h0);
        issue(CTRL_RW, CSR_MCYCLE, 64'h1234, 64'h0);
        issue(CTRL_RW, CSR_MINSTRET, 64'h77, 64'h0);
        idle(10);
        rd(CSR_MCYCLE, v);
        n_chk++; if (v !== 64'h1234) begin n_fail++; $display("FAIL mcycle_hold: got %h want 1234", v); end
        rd(CSR_MINSTRET, v);
        n_chk++; if (v !== 64'h77) begin n_fail++; $display("FAIL minstret_hold: got %h want 77", v); end
        issue(CTRL_RW, CSR_MCYCLE, '1, 64'h0);
        issue(CTRL_RW, CSR_MCOUNTINHIBIT, 64'h0, 64'h0);
        rd(CSR_MCYCLE, v);
        n_chk++; if (v !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL mcycle_max: got %h want ffffffffffffffff", v); end
        rd(CSR_MCYCLE, v);
        n_chk++; if (v !== 64'h0) begin n_fail++; $display("FAIL mcycle_wrap: got %h want 0", v); end
        issue(CTRL_RW, CSR_MINSTRET, 64'h50, 64'h0);
        rd(CSR_MINSTRET, v);
        n_chk++; if (v !== 64'h50) begin n_fail++; $display("FAIL minstret_wr_prec: got %h want 50", v); end
        rd(CSR_MINSTRET, v);
        n_chk++; if (v !== 64'h51) begin n_fail++; $display("FAIL minstret_inc: got %h want 51", v); end
        issue(CTRL_RW, CSR_MCYCLE, 64'h100, 64'h0);
        rd(CSR_MCYCLE, v);
        n_chk++; if (v !== 64'h100) begin n_fail++; $display("FAIL mcycle_wr_prec: got %h want 100", v); end
        rd(CSR_MCYCLE, v);
        n_chk++; if (v !== 64'h101) begin n_fail++; $display("FAIL mcycle_inc: got %h want 101", v); end
    endtask

    task automatic test_reset_midtrap();
        issue_sys(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 64'h0, 64'h1000);
        bus.csr_index = CSR_MCAUSE; #1;
        n_chk++; if (bus.redirect !== 1'b1) begin n_fail++; $display("FAIL pre_rst_redirect: got %0h want 1", bus.redirect); end
        rst = 1'b1; #1;
        n_chk++; if (bus.redirect !== 1'b0 || bus.inst_kill !== 1'b0) begin
            n_fail++; $display("FAIL async_rst_flags: got redirect=%0h kill=%0h want 0/0", bus.redirect, bus.inst_kill); end
        n_chk++; if (bus.redirect_pc !== 64'h0 || bus.csr_read !== 64'h0) begin
            n_fail++; $display("FAIL async_rst_data: got pc=%h read=%h want 0/0", bus.redirect_pc, bus.csr_read); end
        @(negedge clk); clear_inst(); rst = 1'b0;
        rd(CSR_MCAUSE, v);
        n_chk++; if (v !== 64'h0) begin n_fail++; $display("FAIL post_rst_mcause: got %h want 0", v); end
        n_chk++; if (bus.inst_kill !== 1'b0) begin n_fail++; $display("FAIL post_rst_kill: got %0h want 0", bus.inst_kill); end
        rd(CSR_MTVEC, v);
        n_chk++; if (v !== 64'h0) begin n_fail++; $display("FAIL post_rst_mtvec: got %h want 0", v); end
        rd(CSR_MSTATUS, v);
        n_chk++; if (v !== 64'h1800) begin n_fail++; $display("FAIL post_rst_mstatus: got %h want 1800", v); end
    endtask

    initial begin
        test_reset();
        test_csr_rw();
        test_illegal();
        test_ecall_mret();
        test_exceptions();
        test_irq_timer();
        test_irq_priority();
        test_counters();
        test_reset_midtrap();
        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
